// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction-memory read bus between the fetch unit and memory
interface instr_fetch_if;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC, IR, redirect handling and a return-address stack
module instr_fetch #(
  parameter int STACK_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ir_load,
  input  logic               jmp_en,
  input  logic               call_en,
  input  logic               ret_en,
  input  logic [7:0]         jmp_target,
  instr_fetch_if.master      mem,
  output logic [7:0]         IR,
  output logic               ir_valid,
  output logic               busy,
  output logic [7:0]         pc_out,
  output logic               stack_err
);

  localparam int SW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic {ST_IDLE, ST_REQ} state_e;

  state_e         state_q;
  logic [7:0]     pc_q, pc_d;
  logic [7:0]     ir_q;
  logic           ir_valid_q;
  logic [SW-1:0]  sp_q, sp_d;
  logic           err_q, err_d;
  logic           push;
  logic [IW-1:0]  push_idx, top_idx;
  logic [7:0]     stack_q [STACK_DEPTH];

  assign push_idx = sp_q[IW-1:0];
  assign top_idx  = IW'(sp_q - 1'b1);

  // Redirects are only honoured in IDLE; in REQ the PC moves only on an accepted ack.
  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (jmp_en) begin
        pc_d = jmp_target;
      end else if (call_en) begin
        if (sp_q == SW'(STACK_DEPTH)) begin
          err_d = 1'b1;
        end else begin
          push = 1'b1;
          sp_d = sp_q + 1'b1;
          pc_d = jmp_target;
        end
      end else if (ret_en) begin
        if (sp_q == '0) begin
          err_d = 1'b1;
        end else begin
          sp_d = sp_q - 1'b1;
          pc_d = stack_q[top_idx];
        end
      end
    end else if (mem.mem_ack) begin
      pc_d = pc_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= 8'h00;
      ir_q       <= 8'h00;
      ir_valid_q <= 1'b0;
      sp_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      err_q      <= err_d;
      ir_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ir_load) state_q <= ST_REQ;
        end
        ST_REQ: begin
          if (mem.mem_ack) begin
            ir_q       <= mem.mem_rdata;
            ir_valid_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stack contents need no reset: the pointer alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (!reset && push) stack_q[push_idx] <= pc_q;
  end

  assign mem.mem_req  = (state_q == ST_REQ);
  assign mem.mem_addr = pc_q;
  assign busy         = (state_q == ST_REQ);
  assign IR           = ir_q;
  assign ir_valid     = ir_valid_q;
  assign pc_out       = pc_q;
  assign stack_err    = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed vector bench for instr_fetch
module tb_instr_fetch;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ir_load = 1'b0, jmp_en = 1'b0, call_en = 1'b0, ret_en = 1'b0;
  logic [7:0] jmp_target = 8'h00;
  logic [7:0] IR, pc_out;
  logic       ir_valid, busy, stack_err;
  int         total = 0;
  int         bad = 0;

  instr_fetch_if mif ();

  instr_fetch #(.STACK_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .ir_load(ir_load), .jmp_en(jmp_en),
    .call_en(call_en), .ret_en(ret_en), .jmp_target(jmp_target), .mem(mif),
    .IR(IR), .ir_valid(ir_valid), .busy(busy), .pc_out(pc_out), .stack_err(stack_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst, ld, j, c, r;
    logic [7:0] tgt;
    logic       ack;
    logic [7:0] rd;
    logic [7:0] e_pc, e_ir;
    logic       e_v, e_b, e_err;
  } vec_t;

  vec_t vq[$];

  task automatic cmp(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %02h want %02h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic ld, input logic j, input logic c, input logic r,
                      input logic [7:0] tgt, input logic ack, input logic [7:0] rd);
    @(negedge clock);
    reset = rst; ir_load = ld; jmp_en = j; call_en = c; ret_en = r;
    jmp_target = tgt; mif.mem_ack = ack; mif.mem_rdata = rd;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx, input logic [7:0] e_pc, input logic [7:0] e_ir,
                           input logic e_v, input logic e_b, input logic e_err);
    cmp({tag, "_pc"}, idx, pc_out, e_pc);
    cmp({tag, "_ir"}, idx, IR, e_ir);
    cmp({tag, "_irvalid"}, idx, {7'd0, ir_valid}, {7'd0, e_v});
    cmp({tag, "_busy"}, idx, {7'd0, busy}, {7'd0, e_b});
    cmp({tag, "_memreq"}, idx, {7'd0, mif.mem_req}, {7'd0, e_b});
    cmp({tag, "_err"}, idx, {7'd0, stack_err}, {7'd0, e_err});
    if (e_b) cmp({tag, "_addr"}, idx, mif.mem_addr, e_pc);
  endtask

  function automatic vec_t mk(input logic rst, input logic ld, input logic j, input logic c, input logic r,
                              input logic [7:0] tgt, input logic ack, input logic [7:0] rd,
                              input logic [7:0] e_pc, input logic [7:0] e_ir,
                              input logic e_v, input logic e_b, input logic e_err);
    mk = '{rst, ld, j, c, r, tgt, ack, rd, e_pc, e_ir, e_v, e_b, e_err};
  endfunction

  initial begin
    mif.mem_ack = 1'b0;
    mif.mem_rdata = 8'h00;
    //          rst ld j  c  r  tgt    ack rd      pc     ir    v  b  err
    vq.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 8'h01, 8'h01, 8'h01, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 0, 0, 0));
    // wait states: four REQ cycles, ir_load and jmp ignored while busy
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 0, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 0, 1, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 8'h77, 0, 8'h00, 8'h01, 8'h01, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 8'hA5, 8'h02, 8'hA5, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h02, 8'hA5, 0, 0, 0));
    // call / fetch / return
    vq.push_back(mk(0, 0, 1, 0, 0, 8'h05, 0, 8'h00, 8'h05, 8'hA5, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 8'h40, 0, 8'h00, 8'h40, 8'hA5, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h40, 8'hA5, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 8'h3C, 8'h41, 8'h3C, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 8'h05, 8'h3C, 0, 0, 0));
    // ack in IDLE ignored
    vq.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 8'hFF, 8'h05, 8'h3C, 0, 0, 0));
    // PC wrap
    vq.push_back(mk(0, 0, 1, 0, 0, 8'hFF, 0, 8'h00, 8'hFF, 8'h3C, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'hFF, 8'h3C, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 8'h11, 8'h00, 8'h11, 1, 0, 0));
    // priority jmp > ret with concurrent fetch; stack entry 0x00 must survive
    vq.push_back(mk(0, 0, 0, 1, 0, 8'h30, 0, 8'h00, 8'h30, 8'h11, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 1, 8'h20, 0, 8'h00, 8'h20, 8'h11, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 8'h22, 8'h21, 8'h22, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 8'h22, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 8'h22, 0, 0, 1));
    vq.push_back(mk(0, 0, 1, 0, 0, 8'h10, 0, 8'h00, 8'h10, 8'h22, 0, 0, 1));
    // reset mid-fetch with ack on the reset edge and after
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h10, 8'h22, 0, 1, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1, 8'h99, 8'h00, 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 8'h99, 8'h00, 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    // call beats ret
    vq.push_back(mk(0, 0, 0, 1, 1, 8'h08, 0, 8'h00, 8'h08, 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].ld, vq[i].j, vq[i].c, vq[i].r, vq[i].tgt, vq[i].ack, vq[i].rd);
      check_all("vec", i, vq[i].e_pc, vq[i].e_ir, vq[i].e_v, vq[i].e_b, vq[i].e_err);
    end

    // stack overflow: fifth call rejected, then LIFO pops and underflow
    step(1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 1, 0, 8'h10 + 8'(k), 0, 8'h00);
      cmp("ovf_pc", k, pc_out, (k < 4) ? 8'h10 + 8'(k) : 8'h13);
      cmp("ovf_err", k, {7'd0, stack_err}, {7'd0, k == 4});
    end
    begin
      logic [7:0] pops [5];
      pops = '{8'h12, 8'h11, 8'h10, 8'h00, 8'h00};
      for (int k = 0; k < 5; k++) begin
        step(0, 0, 0, 0, 1, 8'h00, 0, 8'h00);
        cmp("pop_pc", k, pc_out, pops[k]);
        cmp("pop_err", k, {7'd0, stack_err}, 8'h01);
      end
    end

    // underflow straight after reset
    step(1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    cmp("unf_rst_err", 0, {7'd0, stack_err}, 8'h00);
    step(0, 0, 1, 0, 0, 8'h33, 0, 8'h00);
    step(0, 0, 0, 0, 1, 8'h00, 0, 8'h00);
    cmp("unf_pc", 0, pc_out, 8'h33);
    cmp("unf_err", 0, {7'd0, stack_err}, 8'h01);

    // minimum latency: ack on first REQ cycle; ir_valid only for one cycle
    step(0, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    cmp("lat_req", 0, {7'd0, mif.mem_req}, 8'h01);
    step(0, 0, 0, 0, 0, 8'h00, 1, 8'h5A);
    cmp("lat_valid", 0, {7'd0, ir_valid}, 8'h01);
    cmp("lat_ir", 0, IR, 8'h5A);
    cmp("lat_pc", 0, pc_out, 8'h34);
    step(0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    cmp("lat_valid_drop", 0, {7'd0, ir_valid}, 8'h00);
    cmp("lat_ir_hold", 0, IR, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter STACK_DEPTH, default 4, SHALL set the number of return-address entries in the call stack (range 1..8).
REQ-002 Port clock, input, 1: SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: SHALL be a synchronous, active-high reset.
REQ-004 Port ir_load, input, 1: SHALL be the fetch request from the control unit; one fetch per sampled high cycle in IDLE.
REQ-005 Port jmp_en, input, 1: SHALL request PC <= jmp_target (JMP/GOTO/taken JZ/JNZ).
REQ-006 Port call_en, input, 1: SHALL request a push of the return address, then PC <= jmp_target.
REQ-007 Port ret_en, input, 1: SHALL request PC <= popped return address.
REQ-008 Port jmp_target, input, 8: SHALL be the redirect target for jmp_en and call_en.
REQ-009 Port mem_req, output, 1: SHALL be the instruction-memory read request.
REQ-010 Port mem_addr, output, 8: SHALL be the read address, valid while mem_req=1.
REQ-011 Port mem_ack, input, 1: SHALL mean mem_rdata is valid this cycle.
REQ-012 Port mem_rdata, input, 8: SHALL be the instruction byte.
REQ-013 Port IR, output, 8: SHALL be the registered instruction presented to the control unit.
REQ-014 Port ir_valid, output, 1: SHALL be a one-cycle pulse when IR is updated.
REQ-015 Port busy, output, 1: SHALL be high while a memory fetch is outstanding.
REQ-016 Port pc_out, output, 8: SHALL be the current PC register.
REQ-017 Port stack_err, output, 1: SHALL be a sticky call-stack overflow/underflow flag.

Function
REQ-018 FSM SHALL have two states: IDLE and REQ; busy = (state == REQ).
REQ-019 In IDLE, redirects SHALL be evaluated with priority jmp_en > call_en > ret_en; only the highest asserted request takes effect.
REQ-020 jmp_en in IDLE SHALL load PC <= jmp_target at the next edge.
REQ-021 call_en in IDLE with stack not full SHALL push the current PC and load PC <= jmp_target at the same edge.
REQ-022 call_en with stack full (STACK_DEPTH entries) SHALL leave PC and the stack unchanged and set stack_err.
REQ-023 ret_en in IDLE with stack not empty SHALL pop the top entry into PC (LIFO).
REQ-024 ret_en with stack empty SHALL leave PC unchanged and set stack_err.
REQ-025 ir_load in IDLE SHALL move the FSM to REQ at the next edge; if a redirect is applied in the same cycle, the fetch SHALL use the redirected PC.
REQ-026 In REQ: mem_req=1 and mem_addr=PC, held stable until mem_ack is sampled high.
REQ-027 On mem_ack in REQ, the FSM SHALL, at that edge: set IR <= mem_rdata, set PC <= PC+1 modulo 256 (0xFF wraps to 0x00), pulse ir_valid for the following cycle, and return to IDLE (mem_req=0).
REQ-028 Latency: ir_load sampled at edge N -> mem_req high from N; with mem_ack sampled at edge M -> IR and ir_valid valid after M; minimum 2 cycles from ir_load to ir_valid.
REQ-029 ir_load, jmp_en, call_en, and ret_en SHALL be ignored while in REQ (no queueing); mem_ack SHALL be ignored in IDLE.
REQ-030 IR SHALL hold its value between fetches; ir_valid SHALL be 0 in every cycle except the one following an accepted mem_ack.
REQ-031 stack_err SHALL remain 1 until reset; the stack pointer SHALL never move outside 0..STACK_DEPTH.

Reset
REQ-032 While reset=1 at an edge: state <= IDLE, PC=0x00, IR=0x00, ir_valid=0, mem_req=0, stack pointer=0, stack_err=0.
REQ-033 Reset during REQ SHALL abort the fetch: mem_req=0 in the cycle after the reset edge, IR unchanged at 0x00, and a late mem_ack ignored.
REQ-034 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-035 Sequential fetch: after reset, ir_load pulse, mem_ack with rdata=0x01 on the first REQ cycle -> mem_addr=0x00, IR=0x01, ir_valid for 1 cycle, pc_out=0x01.
REQ-036 Wait states: mem_ack delayed 3 cycles -> mem_req and mem_addr stable for 4 cycles, busy=1 throughout, ir_load pulses during REQ produce no extra fetch.
REQ-037 Call/return: PC=0x05, call_en with target=0x40 -> PC=0x40; fetch -> PC=0x41; ret_en -> PC=0x05.
REQ-038 Stack limits: 5 calls with STACK_DEPTH=4 -> 5th call ignored, stack_err=1; after reset, ret_en with empty stack -> PC unchanged, stack_err=1.
REQ-039 Wrap and priority: PC=0xFF fetch -> PC=0x00; jmp_en+ret_en+ir_load with target=0x20 -> fetch addr 0x20, stack unchanged.
REQ-040 Reset mid-fetch: reset in REQ, then mem_ack -> mem_req=0, IR=0x00, ir_valid never asserted.
